// File: rtl/svc_rv_wb_arb_if.sv
// Writeback arbiter bus: execute and long-latency result inputs, regfile write port and status.
// The arbiter connects to the slave modport; upstream and regfile-side logic use master.
interface svc_rv_wb_arb_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic [4:0]      ex_rd_addr;
  logic [XLEN-1:0] ex_rd_data;
  logic            lu_valid;
  logic            lu_ready;
  logic [4:0]      lu_rd_addr;
  logic [XLEN-1:0] lu_rd_data;
  logic            rd_en;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            busy;
  logic            ex_stall;

  modport master (
    output ex_valid, ex_rd_addr, ex_rd_data,
    output lu_valid, lu_rd_addr, lu_rd_data,
    input  lu_ready,
    input  rd_en, rd_addr, rd_data, busy, ex_stall
  );

  modport slave (
    input  ex_valid, ex_rd_addr, ex_rd_data,
    input  lu_valid, lu_rd_addr, lu_rd_data,
    output lu_ready,
    output rd_en, rd_addr, rd_data, busy, ex_stall
  );
endinterface

// File: rtl/svc_rv_wb_arb.sv
// Writeback arbiter: merges execute and buffered long-latency results onto one registered regfile write port.
// Optional starvation guard enabled by defining SVC_RV_WB_FAIR_EN.
module svc_rv_wb_arb #(
  parameter int XLEN         = 32,
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             rst,
  svc_rv_wb_arb_if.slave  wb
);

  localparam int IW = $clog2(BUF_DEPTH);
  localparam int PW = IW + 1;

  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("svc_rv_wb_arb: BUF_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr_n;
  logic [PW-1:0]        rd_ptr_n;
  logic [BUF_DEPTH-1:0] buf_vld;
  logic [BUF_DEPTH-1:0] buf_vld_n;
  logic [4:0]           buf_addr [BUF_DEPTH];
  logic [XLEN-1:0]      buf_data [BUF_DEPTH];

  logic [IW-1:0]        head_idx;
  logic [IW-1:0]        tail_idx;
  logic                 empty;
  logic                 full;
  logic                 ex_wr;
  logic                 lu_acc;
  logic                 head_vld;
  logic                 head_pop;
  logic                 bypass;
  logic                 push;

  logic                 wr_en_n;
  logic [4:0]           wr_addr_n;
  logic [XLEN-1:0]      wr_data_n;

  logic                 rd_en_p1;
  logic [4:0]           rd_addr_p1;
  logic [XLEN-1:0]      rd_data_p1;
  logic                 busy_p1;
  logic                 stall_p1;

  // Stage 0: arbitration and buffer bookkeeping from registered state and current inputs
  always_comb begin
    head_idx = rd_ptr[IW-1:0];
    tail_idx = wr_ptr[IW-1:0];
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    ex_wr    = wb.ex_valid && (wb.ex_rd_addr != 5'd0);
    lu_acc   = wb.lu_valid && !full;
    head_vld = !empty && buf_vld[head_idx];
    // An invalid (squashed) head always retires; a valid one only when execute is idle.
    head_pop = !empty && (!buf_vld[head_idx] || !ex_wr);
    bypass   = empty && !ex_wr && lu_acc;
    push     = lu_acc && !bypass && (wb.lu_rd_addr != 5'd0) &&
               !(ex_wr && (wb.ex_rd_addr == wb.lu_rd_addr));
    wr_ptr_n = wr_ptr + PW'(push);
    rd_ptr_n = rd_ptr + PW'(head_pop);
  end

  always_comb begin
    buf_vld_n = buf_vld;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (ex_wr && (buf_addr[i] == wb.ex_rd_addr)) begin
        buf_vld_n[i] = 1'b0;
      end
    end
    // The pushed address never matches a same-cycle execute write, so no squash conflict here.
    if (push) begin
      buf_vld_n[tail_idx] = 1'b1;
    end
  end

  always_comb begin
    wr_en_n   = 1'b0;
    wr_addr_n = rd_addr_p1;
    wr_data_n = rd_data_p1;
    if (ex_wr) begin
      wr_en_n   = 1'b1;
      wr_addr_n = wb.ex_rd_addr;
      wr_data_n = wb.ex_rd_data;
    end else if (head_vld) begin
      wr_en_n   = 1'b1;
      wr_addr_n = buf_addr[head_idx];
      wr_data_n = buf_data[head_idx];
    end else if (bypass && (wb.lu_rd_addr != 5'd0)) begin
      wr_en_n   = 1'b1;
      wr_addr_n = wb.lu_rd_addr;
      wr_data_n = wb.lu_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      buf_vld <= '0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      buf_vld <= buf_vld_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[tail_idx] <= wb.lu_rd_addr;
      buf_data[tail_idx] <= wb.lu_rd_data;
    end
  end

  // Stage 1: registered regfile write port and status
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_p1   <= 1'b0;
      rd_addr_p1 <= 5'd0;
      rd_data_p1 <= '0;
      busy_p1    <= 1'b0;
    end else begin
      rd_en_p1   <= wr_en_n;
      rd_addr_p1 <= wr_addr_n;
      rd_data_p1 <= wr_data_n;
      busy_p1    <= (wr_ptr_n != rd_ptr_n);
    end
  end

`ifdef SVC_RV_WB_FAIR_EN
  localparam int CW = $clog2(STARVE_LIMIT + 2);

  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_n;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c >= CW'(STARVE_LIMIT + 1)) begin
      return c;
    end
    return c + CW'(1);
  endfunction

  always_comb begin
    wait_cnt_n = wait_cnt;
    if (empty || head_pop) begin
      wait_cnt_n = '0;
    end else if (head_vld) begin
      wait_cnt_n = sat_inc(wait_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      stall_p1 <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_n;
      stall_p1 <= (wait_cnt_n == CW'(STARVE_LIMIT));
    end
  end
`else
  assign stall_p1 = 1'b0;
`endif

  assign wb.lu_ready = !full;
  assign wb.rd_en    = rd_en_p1;
  assign wb.rd_addr  = rd_addr_p1;
  assign wb.rd_data  = rd_data_p1;
  assign wb.busy     = busy_p1;
  assign wb.ex_stall = stall_p1;

endmodule

// File: tb/tb_svc_rv_wb_arb.sv
// Bench for svc_rv_wb_arb: directed vector table, multi-cycle sequences, and randomized traffic
// against a queue-based reference model.
module tb_svc_rv_wb_arb;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  svc_rv_wb_arb_if #(.XLEN(XLEN)) bus ();

  svc_rv_wb_arb #(.XLEN(XLEN), .BUF_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .wb (bus)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.ex_valid   = ev;
    bus.ex_rd_addr = ea;
    bus.ex_rd_data = ed;
    bus.lu_valid   = lv;
    bus.lu_rd_addr = la;
    bus.lu_rd_data = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the buffer as a queue of {valid, addr, data}
  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  int          m_wait;
  logic        m_stall;
  logic        e_en;
  logic [4:0]  e_a;
  logic [31:0] e_d;

  task automatic model_reset();
    q.delete();
    m_wait  = 0;
    m_stall = 1'b0;
  endtask

  task automatic model_step(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                            input logic lv, input logic [4:0] la, input logic [31:0] ld,
                            output logic acc);
    logic exw, was_empty, popped;
    exw       = ev && (ea != 0);
    was_empty = (q.size() == 0);
    acc       = lv && (q.size() < DEPTH);
    popped    = !was_empty && (!q[0].v || !exw);
    e_en = 1'b0; e_a = 5'd0; e_d = 32'd0;
    if (exw) begin
      e_en = 1'b1; e_a = ea; e_d = ed;
    end else if (!was_empty && q[0].v) begin
      e_en = 1'b1; e_a = q[0].a; e_d = q[0].d;
    end else if (was_empty && acc && la != 0) begin
      e_en = 1'b1; e_a = la; e_d = ld;
    end
    if (was_empty || popped) m_wait = 0;
    else if (m_wait <= LIMIT) m_wait++;
    m_stall = (m_wait == LIMIT);
    if (popped) void'(q.pop_front());
    if (exw) foreach (q[i]) if (q[i].a == ea) q[i].v = 1'b0;
    if (acc && !(was_empty && !exw) && la != 0 && !(exw && la == ea))
      q.push_back('{1'b1, la, ld});
  endtask

  typedef struct {
    logic        ev;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        en;
    logic [4:0]  a;
    logic [31:0] d;
    logic        busy;
    logic        rdy;
  } vec_t;

  vec_t vt[17];

  initial begin
    logic        ev, lv, lu_pend, acc, exp_stall;
    logic [4:0]  ea, la;
    logic [31:0] ed, ld;

    vt[0]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'h12345678, 1'b1, 5'd5,  32'h12345678, 1'b0, 1'b1};
    vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1};
    vt[2]  = '{1'b1, 5'd3,  32'h33333333, 1'b1, 5'd4,  32'h44444444, 1'b1, 5'd3,  32'h33333333, 1'b1, 1'b1};
    vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h44444444, 1'b0, 1'b1};
    vt[4]  = '{1'b1, 5'd1,  32'h00000001, 1'b1, 5'd7,  32'h11111111, 1'b1, 5'd1,  32'h00000001, 1'b1, 1'b1};
    vt[5]  = '{1'b1, 5'd7,  32'h22222222, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h22222222, 1'b1, 1'b1};
    vt[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1};
    vt[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1};
    vt[8]  = '{1'b1, 5'd2,  32'h00000002, 1'b1, 5'd0,  32'hDEADBEEF, 1'b1, 5'd2,  32'h00000002, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 5'd1,  32'h000000A1, 1'b1, 5'd10, 32'h0000000A, 1'b1, 5'd1,  32'h000000A1, 1'b1, 1'b1};
    vt[10] = '{1'b1, 5'd1,  32'h000000A2, 1'b1, 5'd11, 32'h0000000B, 1'b1, 5'd1,  32'h000000A2, 1'b1, 1'b0};
    vt[11] = '{1'b1, 5'd1,  32'h000000A3, 1'b1, 5'd12, 32'h0000000C, 1'b1, 5'd1,  32'h000000A3, 1'b1, 1'b0};
    vt[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h0000000C, 1'b1, 5'd10, 32'h0000000A, 1'b1, 1'b1};
    vt[13] = '{1'b1, 5'd1,  32'h000000A4, 1'b1, 5'd12, 32'h0000000C, 1'b1, 5'd1,  32'h000000A4, 1'b1, 1'b0};
    vt[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 32'h0000000B, 1'b1, 1'b1};
    vt[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h0000000C, 1'b0, 1'b1};
    vt[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1};

    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
      tick();
    end
    chk("reset.rd_en",    32'(bus.rd_en),    32'd0);
    chk("reset.rd_addr",  32'(bus.rd_addr),  32'd0);
    chk("reset.rd_data",  bus.rd_data,       32'd0);
    chk("reset.busy",     32'(bus.busy),     32'd0);
    chk("reset.lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("reset.ex_stall", 32'(bus.ex_stall), 32'd0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].ev, vt[i].ea, vt[i].ed, vt[i].lv, vt[i].la, vt[i].ld);
      tick();
      chk($sformatf("vec%0d.rd_en", i), 32'(bus.rd_en), 32'(vt[i].en));
      if (vt[i].en) begin
        chk($sformatf("vec%0d.rd_addr", i), 32'(bus.rd_addr), 32'(vt[i].a));
        chk($sformatf("vec%0d.rd_data", i), bus.rd_data, vt[i].d);
      end
      chk($sformatf("vec%0d.busy", i),     32'(bus.busy),     32'(vt[i].busy));
      chk($sformatf("vec%0d.lu_ready", i), 32'(bus.lu_ready), 32'(vt[i].rdy));
    end

    // Reset while the buffer is full discards its entries
    drive(1, 5'd1, 32'h1, 1, 5'd6, 32'h66666666);
    tick();
    drive(1, 5'd1, 32'h1, 1, 5'd7, 32'h77777777);
    tick();
    chk("midrst.pre_ready", 32'(bus.lu_ready), 32'd0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    chk("midrst.busy",  32'(bus.busy),     32'd0);
    chk("midrst.ready", 32'(bus.lu_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst.rd_en%0d", i), 32'(bus.rd_en), 32'd0);
    end

`ifdef SVC_RV_WB_FAIR_EN
    // Starvation guard: one stall pulse after LIMIT waiting cycles
    drive(1, 5'd1, 32'h1, 1, 5'd9, 32'h99999999);
    tick();
    chk("fair.busy", 32'(bus.busy), 32'd1);
    for (int k = 1; k <= LIMIT; k++) begin
      drive(1, 5'd1, 32'(k), 0, 0, 0);
      tick();
      chk($sformatf("fair.stall%0d", k), 32'(bus.ex_stall), 32'(k == LIMIT));
      chk($sformatf("fair.ex_addr%0d", k), 32'(bus.rd_addr), 32'd1);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("fair.rd_en",   32'(bus.rd_en),    32'd1);
    chk("fair.rd_addr", 32'(bus.rd_addr),  32'd9);
    chk("fair.rd_data", bus.rd_data,       32'h99999999);
    chk("fair.unstall", 32'(bus.ex_stall), 32'd0);
    tick();
    chk("fair.idle", 32'(bus.ex_stall), 32'd0);
`endif

    // Randomized traffic against the reference model
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    model_reset();
    lu_pend = 1'b0;
    la = 5'd0;
    ld = 32'd0;
    for (int c = 0; c < 2000; c++) begin
      ev = ($urandom_range(99) < 60);
`ifdef SVC_RV_WB_FAIR_EN
      if (m_stall) ev = 1'b0;
`endif
      ea = 5'($urandom_range(7));
      ed = $urandom;
      if (!lu_pend) begin
        lu_pend = ($urandom_range(99) < 50);
        la = 5'($urandom_range(7));
        ld = $urandom;
      end
      lv = lu_pend;
      drive(ev, ea, ed, lv, la, ld);
      model_step(ev, ea, ed, lv, la, ld, acc);
      if (acc) lu_pend = 1'b0;
      tick();
`ifdef SVC_RV_WB_FAIR_EN
      exp_stall = m_stall;
`else
      exp_stall = 1'b0;
`endif
      chk($sformatf("rnd%0d.rd_en", c), 32'(bus.rd_en), 32'(e_en));
      if (e_en) begin
        chk($sformatf("rnd%0d.rd_addr", c), 32'(bus.rd_addr), 32'(e_a));
        chk($sformatf("rnd%0d.rd_data", c), bus.rd_data, e_d);
      end
      chk($sformatf("rnd%0d.busy", c),     32'(bus.busy),     32'(q.size() > 0));
      chk($sformatf("rnd%0d.lu_ready", c), 32'(bus.lu_ready), 32'(q.size() < DEPTH));
      chk($sformatf("rnd%0d.ex_stall", c), 32'(bus.ex_stall), 32'(exp_stall));
      chk($sformatf("rnd%0d.x0", c), 32'(bus.rd_en && bus.rd_addr == 5'd0), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
